// File: rtl/operand_fetch_stage_if.sv
// Port bundle for the operand-fetch stage: decode handshake, register file read port,
// MEM/WB bypass sources, downstream hold and the ID/EX register outputs.
interface operand_fetch_stage_if #(parameter int STALL_CNT_W = 32);
  logic                   in_valid;
  logic                   in_ready;
  logic [4:0]             in_rn;
  logic [4:0]             in_rm;
  logic [4:0]             in_rd;
  logic                   in_regwrite;
  logic                   in_memread;

  logic [4:0]             rf_rr1;
  logic [4:0]             rf_rr2;
  logic [63:0]            rf_rd1;
  logic [63:0]            rf_rd2;

  logic                   mem_valid;
  logic                   mem_regwrite;
  logic                   mem_memread;
  logic [4:0]             mem_rd;
  logic [63:0]            mem_data;

  logic                   wb_regwrite;
  logic [4:0]             wb_rd;
  logic [63:0]            wb_data;

  logic                   ex_hold;

  logic                   out_valid;
  logic                   out_regwrite;
  logic                   out_memread;
  logic [4:0]             out_rd;
  logic [63:0]            out_a;
  logic [63:0]            out_b;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport master (
    output in_valid, in_rn, in_rm, in_rd, in_regwrite, in_memread,
    input  in_ready,
    input  rf_rr1, rf_rr2,
    output rf_rd1, rf_rd2,
    output mem_valid, mem_regwrite, mem_memread, mem_rd, mem_data,
    output wb_regwrite, wb_rd, wb_data,
    output ex_hold,
    input  out_valid, out_regwrite, out_memread, out_rd, out_a, out_b, stall_cycles
  );

  modport slave (
    input  in_valid, in_rn, in_rm, in_rd, in_regwrite, in_memread,
    output in_ready,
    output rf_rr1, rf_rr2,
    input  rf_rd1, rf_rd2,
    input  mem_valid, mem_regwrite, mem_memread, mem_rd, mem_data,
    input  wb_regwrite, wb_rd, wb_data,
    input  ex_hold,
    output out_valid, out_regwrite, out_memread, out_rd, out_a, out_b, stall_cycles
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// Operand fetch with MEM/WB bypass and hazard bubbles; 1-cycle latency into ID/EX.
// Backpressure: in_ready drops on ex_hold (stage frozen) or an unbypassable hazard (bubble).
module operand_fetch_stage #(
  parameter int STALL_CNT_W = 32
) (
  input logic                  clk,
  input logic                  reset,
  operand_fetch_stage_if.slave bus
);

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic [4:0]  rd;
    logic [63:0] a;
    logic [63:0] b;
  } idex_t;

  idex_t                  idex_q;
  logic [STALL_CNT_W-1:0] stall_q;
  logic [63:0]            opnd_a;
  logic [63:0]            opnd_b;
  logic                   hazard;
  logic                   mem_fwd_en;
  logic                   mem_load;
  logic                   ex_wr;

  // Only a completed ALU result in MEM is forwardable; a load's mem_data is just its address.
  assign mem_fwd_en = bus.mem_valid & bus.mem_regwrite & ~bus.mem_memread;
  assign mem_load   = bus.mem_valid & bus.mem_regwrite & bus.mem_memread;
  assign ex_wr      = idex_q.valid & idex_q.regwrite;

  function automatic logic [63:0] pick_operand(
    input logic [4:0]  src,
    input logic [63:0] rf_dat,
    input logic        mem_en,
    input logic [4:0]  mem_rd,
    input logic [63:0] mem_dat,
    input logic        wb_en,
    input logic [4:0]  wb_rd,
    input logic [63:0] wb_dat
  );
    if (src == XZR)                   return 64'd0;
    else if (mem_en && mem_rd == src) return mem_dat;
    else if (wb_en && wb_rd == src)   return wb_dat;
    else                              return rf_dat;
  endfunction

  function automatic logic src_hazard(
    input logic [4:0] src,
    input logic       ex_en,
    input logic [4:0] ex_rd,
    input logic       load_en,
    input logic [4:0] load_rd
  );
    return (src != XZR) && ((ex_en && ex_rd == src) || (load_en && load_rd == src));
  endfunction

  always_comb begin
    opnd_a = pick_operand(bus.in_rn, bus.rf_rd1, mem_fwd_en, bus.mem_rd, bus.mem_data,
                          bus.wb_regwrite, bus.wb_rd, bus.wb_data);
    opnd_b = pick_operand(bus.in_rm, bus.rf_rd2, mem_fwd_en, bus.mem_rd, bus.mem_data,
                          bus.wb_regwrite, bus.wb_rd, bus.wb_data);
    hazard = bus.in_valid &
             (src_hazard(bus.in_rn, ex_wr, idex_q.rd, mem_load, bus.mem_rd) |
              src_hazard(bus.in_rm, ex_wr, idex_q.rd, mem_load, bus.mem_rd));
  end

  assign bus.rf_rr1   = bus.in_rn;
  assign bus.rf_rr2   = bus.in_rm;
  assign bus.in_ready = reset & ~bus.ex_hold & ~hazard;

  // Hold beats hazard: a frozen stage neither bubbles nor counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idex_q  <= '0;
      stall_q <= '0;
    end else if (!bus.ex_hold) begin
      if (hazard) begin
        idex_q.valid <= 1'b0;
        if (stall_q != '1) stall_q <= stall_q + 1'b1;
      end else if (bus.in_valid) begin
        idex_q.valid    <= 1'b1;
        idex_q.regwrite <= bus.in_regwrite;
        idex_q.memread  <= bus.in_memread;
        idex_q.rd       <= bus.in_rd;
        idex_q.a        <= opnd_a;
        idex_q.b        <= opnd_b;
      end else begin
        idex_q.valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid    = idex_q.valid;
  assign bus.out_regwrite = idex_q.regwrite;
  assign bus.out_memread  = idex_q.memread;
  assign bus.out_rd       = idex_q.rd;
  assign bus.out_a        = idex_q.a;
  assign bus.out_b        = idex_q.b;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed hazard/bypass scenarios, then a random instruction stream checked against an
// in-order architectural model and a cycle-level issue schedule.
module tb_operand_fetch_stage;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;
  localparam int N   = 48;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_fetch_stage_if #(.STALL_CNT_W(CW)) bus ();
  operand_fetch_stage #(.STALL_CNT_W(CW)) dut (.clk(clk), .reset(rst_n), .bus(bus));

  logic [63:0] rf [32];
  assign bus.rf_rd1 = rf[bus.rf_rr1];
  assign bus.rf_rd2 = rf[bus.rf_rr2];

  int npass  = 0;
  int ntotal = 0;
  int cyc    = 0;

  // Downstream pipeline environment (used in the random phase)
  logic        pipe_en  = 1'b0;
  logic [63:0] mem_res  = 64'd0;
  logic        last_acc = 1'b0;
  logic        ex_v, ex_rw, ex_mr;
  logic [4:0]  ex_rd;
  logic [63:0] ex_a, ex_b;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] alu_fn(input logic [63:0] a, input logic [63:0] b);
    return a + b + 64'd1;
  endfunction

  function automatic logic [63:0] load_fn(input logic [63:0] a, input logic [63:0] b);
    return {a[31:0], b[63:32]} ^ 64'hC3C3_5A5A_0F0F_9696;
  endfunction

  task automatic clr();
    bus.in_valid = 0; bus.in_rn = 0; bus.in_rm = 0; bus.in_rd = 0;
    bus.in_regwrite = 0; bus.in_memread = 0;
    bus.mem_valid = 0; bus.mem_regwrite = 0; bus.mem_memread = 0; bus.mem_rd = 0;
    bus.mem_data = 0; bus.wb_regwrite = 0; bus.wb_rd = 0; bus.wb_data = 0;
    bus.ex_hold = 0;
  endtask

  task automatic issue(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                       input logic rw, input logic mr);
    bus.in_valid = 1; bus.in_rn = rn; bus.in_rm = rm; bus.in_rd = rd;
    bus.in_regwrite = rw; bus.in_memread = mr;
  endtask

  task automatic drive_mem(input logic v, input logic rw, input logic mr,
                           input logic [4:0] rd, input logic [63:0] d);
    bus.mem_valid = v; bus.mem_regwrite = rw; bus.mem_memread = mr;
    bus.mem_rd = rd; bus.mem_data = d;
  endtask

  // One clock: sample pre-edge state at negedge, return at posedge+1.
  task automatic step();
    @(negedge clk);
    ex_v = bus.out_valid; ex_rw = bus.out_regwrite; ex_mr = bus.out_memread;
    ex_rd = bus.out_rd; ex_a = bus.out_a; ex_b = bus.out_b;
    last_acc = bus.in_valid && bus.in_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (pipe_en) begin
      if (bus.wb_regwrite && bus.wb_rd != 5'd31) rf[bus.wb_rd] = bus.wb_data;
      bus.wb_regwrite = bus.mem_valid && bus.mem_regwrite;
      bus.wb_rd       = bus.mem_rd;
      bus.wb_data     = mem_res;
      drive_mem(ex_v, ex_rw, ex_mr, ex_rd, alu_fn(ex_a, ex_b));
      mem_res = ex_mr ? load_fn(ex_a, ex_b) : alu_fn(ex_a, ex_b);
    end
  endtask

  // Called at posedge+1; asserts reset away from any edge and returns at posedge+1.
  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    chk("rst_async_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_stall", bus.stall_cycles, 0);
    clr();
    #3 rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] arch [32];
    int          t_m  [N];
    logic [4:0]  h_rd [N];
    logic        h_rw [N];
    logic        h_mr [N];
    logic [4:0]  rn, rm, rd;
    logic        rw, mr, got, blocked;
    int          p, t, run_stall, gap;
    logic [63:0] ea, eb;

    for (int i = 0; i < 32; i++) rf[i] = 64'd0;
    clr();

    // Reset state
    #2;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_a", bus.out_a, 0);
    chk("reset_out_b", bus.out_b, 0);
    chk("reset_out_rd", bus.out_rd, 0);
    chk("reset_out_rw_mr", {bus.out_regwrite, bus.out_memread}, 0);
    chk("reset_in_ready", bus.in_ready, 0);
    #10 rst_n = 1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", bus.in_ready, 1);
    chk("idle_out_valid", bus.out_valid, 0);
    chk("idle_stall", bus.stall_cycles, 0);

    // Same-cycle WB bypass against a stale register file
    rf[3] = 64'd0;
    bus.wb_regwrite = 1; bus.wb_rd = 3; bus.wb_data = 64'hAAAA;
    issue(5'd3, 5'd31, 5'd1, 1, 0);
    step();
    chk("wb_bypass_valid", bus.out_valid, 1);
    chk("wb_bypass_a", bus.out_a, 64'hAAAA);
    chk("wb_bypass_b_x31", bus.out_b, 0);
    chk("wb_bypass_rd", bus.out_rd, 1);

    // Reset mid-stream with out_valid high
    do_reset();

    // X31: never hazarded, never forwarded
    rf[31] = 64'd0;
    issue(5'd0, 5'd0, 5'd31, 1, 0);
    step();
    issue(5'd31, 5'd31, 5'd4, 0, 0);
    bus.wb_regwrite = 1; bus.wb_rd = 31; bus.wb_data = 64'hFFFF;
    drive_mem(1, 1, 1, 5'd31, 64'h55);
    #1;
    chk("x31_in_ready", bus.in_ready, 1);
    step();
    chk("x31_valid", bus.out_valid, 1);
    chk("x31_a", bus.out_a, 0);
    chk("x31_stall", bus.stall_cycles, 0);
    do_reset();

    // ALU dependency: one bubble, then MEM forwarding
    rf[5] = 64'h9999; rf[0] = 64'h2;
    issue(5'd0, 5'd0, 5'd5, 1, 0);
    step();
    issue(5'd0, 5'd5, 5'd6, 0, 0);
    #1;
    chk("alu_dep_in_ready", bus.in_ready, 0);
    step();
    chk("alu_dep_bubble", bus.out_valid, 0);
    chk("alu_dep_stall", bus.stall_cycles, 1);
    drive_mem(1, 1, 0, 5'd5, 64'h1234);
    step();
    chk("alu_dep_valid", bus.out_valid, 1);
    chk("alu_dep_b", bus.out_b, 64'h1234);
    chk("alu_dep_stall2", bus.stall_cycles, 1);
    do_reset();

    // Load-use: two bubbles, then WB forwarding
    rf[7] = 64'd0;
    issue(5'd0, 5'd0, 5'd7, 1, 1);
    step();
    issue(5'd7, 5'd31, 5'd8, 1, 0);
    step();
    chk("load_use_bubble1", bus.out_valid, 0);
    drive_mem(1, 1, 1, 5'd7, 64'd0);
    step();
    chk("load_use_bubble2", bus.out_valid, 0);
    chk("load_use_stall", bus.stall_cycles, 2);
    drive_mem(0, 0, 0, 5'd0, 64'd0);
    bus.wb_regwrite = 1; bus.wb_rd = 7; bus.wb_data = 64'hBEEF;
    step();
    chk("load_use_valid", bus.out_valid, 1);
    chk("load_use_a", bus.out_a, 64'hBEEF);
    do_reset();

    // ex_hold during a pending hazard
    rf[0] = 64'h10;
    issue(5'd0, 5'd0, 5'd9, 1, 0);
    step();
    issue(5'd9, 5'd0, 5'd2, 0, 0);
    bus.ex_hold = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_rd", bus.out_rd, 9);
      chk("hold_a", bus.out_a, 64'h10);
      chk("hold_stall", bus.stall_cycles, 0);
      #1;
      chk("hold_in_ready", bus.in_ready, 0);
    end
    bus.ex_hold = 0;
    step();
    chk("hold_release_bubble", bus.out_valid, 0);
    chk("hold_release_stall", bus.stall_cycles, 1);
    drive_mem(1, 1, 0, 5'd9, 64'h77);
    step();
    chk("hold_release_a", bus.out_a, 64'h77);
    chk("hold_release_valid", bus.out_valid, 1);
    do_reset();

    // Counter saturation under a persistent load dependency
    drive_mem(1, 1, 1, 5'd7, 64'd0);
    issue(5'd7, 5'd0, 5'd1, 0, 0);
    repeat (SAT - 1) step();
    chk("sat_near", bus.stall_cycles, SAT - 1);
    step();
    chk("sat_max", bus.stall_cycles, SAT);
    repeat (3) step();
    chk("sat_hold", bus.stall_cycles, SAT);
    chk("sat_bubble", bus.out_valid, 0);
    do_reset();

    // Random stream: architectural values plus expected issue cycles
    for (int i = 0; i < 31; i++) rf[i] = {$urandom, $urandom};
    rf[31] = 64'd0;
    for (int i = 0; i < 32; i++) arch[i] = rf[i];
    pipe_en = 1; mem_res = 64'd0; cyc = 0; run_stall = 0;
    for (int i = 0; i < N; i++) begin
      p  = $urandom_range(0, 6);  rn = (p == 6) ? 5'd31 : 5'(p);
      p  = $urandom_range(0, 6);  rm = (p == 6) ? 5'd31 : 5'(p);
      p  = $urandom_range(0, 6);  rd = (p == 6) ? 5'd31 : 5'(p);
      rw = ($urandom_range(0, 4) != 0);
      mr = rw && ($urandom_range(0, 2) == 0);
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      repeat (gap) step();
      issue(rn, rm, rd, rw, mr);
      p = cyc + 1;
      // Earliest edge at which no source is still in EX or is a load in MEM
      t = p;
      do begin
        blocked = 0;
        for (int j = (i >= 2 ? i - 2 : 0); j < i; j++) begin
          if (h_rw[j] && (t - t_m[j] == 1 || (h_mr[j] && t - t_m[j] == 2))) begin
            if ((rn != 5'd31 && h_rd[j] == rn) || (rm != 5'd31 && h_rd[j] == rm)) blocked = 1;
          end
        end
        if (blocked) t++;
      end while (blocked);
      run_stall += t - p;
      t_m[i] = t; h_rd[i] = rd; h_rw[i] = rw; h_mr[i] = mr;
      ea = (rn == 5'd31) ? 64'd0 : arch[rn];
      eb = (rm == 5'd31) ? 64'd0 : arch[rm];

      got = 0;
      for (int k = 0; k < 12 && !got; k++) begin
        step();
        got = last_acc;
      end
      chk("rnd_accepted", got, 1);
      chk("rnd_accept_cycle", cyc, t);
      chk("rnd_valid", bus.out_valid, 1);
      chk("rnd_a", bus.out_a, ea);
      chk("rnd_b", bus.out_b, eb);
      chk("rnd_rd", bus.out_rd, rd);
      chk("rnd_rw_mr", {bus.out_regwrite, bus.out_memread}, {rw, mr});
      chk("rnd_stall", bus.stall_cycles, (run_stall > SAT) ? SAT : run_stall);
      bus.in_valid = 0;
      if (rw && rd != 5'd31) arch[rd] = mr ? load_fn(ea, eb) : alu_fn(ea, eb);
    end
    pipe_en = 0;

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Decode/operand-fetch pipeline stage sitting directly upstream of the EX stage and wrapped around the 32x64 register file. It drives the register file read addresses, resolves read-after-write hazards by bypassing results from the MEM and WB stages, stalls on dependencies it cannot bypass, and registers the resolved operands into the ID/EX pipeline register. A saturating counter reports cycles lost to hazard stalls.

## Interface
Parameters:
- STALL_CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; clears all state immediately when low.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts the presented instruction this cycle.
- in_rn, in_rm, in_rd  in  5 each  source 1, source 2 and destination register numbers.
- in_regwrite, in_memread  in  1 each  instruction writes rd; instruction is a load.
- rf_rr1, rf_rr2  out  5 each  register file read addresses.
- rf_rd1, rf_rd2  in  64 each  register file read data, combinational from rf_rr1/rf_rr2.
- mem_valid, mem_regwrite, mem_memread  in  1 each  MEM-stage instruction status.
- mem_rd  in  5  MEM-stage destination.
- mem_data  in  64  MEM-stage ALU result. Valid only when mem_memread=0.
- wb_regwrite  in  1  WB write enable. This is the same signal that drives the register file RegWrite.
- wb_rd  in  5  WB destination.
- wb_data  in  64  WB write data.
- ex_hold  in  1  downstream stall; freezes this stage.
- out_valid, out_regwrite, out_memread  out  1 each  ID/EX register fields.
- out_rd  out  5  ID/EX destination.
- out_a, out_b  out  64 each  resolved operands.
- stall_cycles  out  STALL_CNT_W  saturating count of hazard-stall cycles.

## Operation
- rf_rr1 = in_rn and rf_rr2 = in_rm, both combinational.
- Operand resolution for each source s (rn→a, rm→b) applies the first matching rule below:
  1. s == 31 gives 0. X31 is never forwarded or hazarded.
  2. mem_valid & mem_regwrite & !mem_memread & mem_rd == s gives mem_data.
  3. wb_regwrite & wb_rd == s gives wb_data. This covers the same-cycle write/read, where the register file still returns the old value.
  4. Otherwise the register file data is used.
- A hazard exists when in_valid and either source s ≠ 31 matches one of:
  - EX dependency: out_valid & out_regwrite & out_rd == s. The EX result is not yet available.
  - MEM load dependency: mem_valid & mem_regwrite & mem_memread & mem_rd == s.
- in_ready = !ex_hold & !hazard.
- Per-cycle update, highest priority first:
  - ex_hold=1: all ID/EX fields hold. Nothing is accepted.
  - hazard=1: insert a bubble. out_valid←0 and the other fields are don't-care (hold them). stall_cycles increments.
  - in_valid=1: capture out_a, out_b, out_rd, out_regwrite, out_memread and set out_valid←1.
  - otherwise: out_valid←0.
- stall_cycles saturates at all-ones and never wraps. It counts only hazard bubbles, never ex_hold cycles.
- A load followed by a dependent instruction stalls 2 cycles: first an EX dependency, then a MEM load dependency. The operand then comes from WB forwarding.

## Timing
- Reset values: out_valid=0, out_regwrite=0, out_memread=0, out_rd=0, out_a=0, out_b=0, stall_cycles=0.
- in_ready is combinational and low while reset is asserted.
- Reset asserted mid-operation discards the held instruction; out_valid falls asynchronously.
- Latency is 1 cycle: an instruction accepted at edge N appears on out_* after edge N.
- The handshake completes on a posedge with in_valid & in_ready. Decode must hold its fields while in_ready=0.
- A non-load ALU dependency stalls exactly 1 cycle. The instruction is then accepted with the value forwarded from mem_data.
- ex_hold and a hazard together: the hold wins, no bubble is inserted, and the counter does not increment.

## Test plan
- Reset then idle: all outputs 0 and in_ready=1. Assert reset mid-stream with out_valid=1 → out_valid=0 immediately.
- Same-cycle WB bypass: wb_regwrite=1, wb_rd=3, wb_data=0xAAAA; issue rn=3 with rf_rd1 stale at 0 → out_a=0xAAAA next cycle.
- X31 handling: rn=31, with wb_rd=31, wb_data=0xFFFF and an EX-stage instruction writing rd=31 → no stall, out_a=0.
- ALU dependency: issue ADD rd=5, then an instruction with rm=5 → 1 bubble (out_valid=0, stall_cycles=1). The next cycle takes out_b=mem_data (0x1234).
- Load-use: issue a load rd=7, then rn=7 → 2 bubbles (stall_cycles=2). The instruction is then accepted with out_a=wb_data (0xBEEF).
- ex_hold during hazard: hold for 3 cycles with a pending dependency → out_* frozen, in_ready=0, stall_cycles unchanged. The stall resumes after release. Also preload the counter near its maximum and confirm it saturates at all-ones.
